div_iter: RTL and testbench
===========================

Name: div_iter

Overview:
- Iterative radix-2 restoring divider, 32-bit signed/unsigned; produces quotient and remainder.
- Sits in the execute stage beside the pipelined Booth/Wallace multiplier and shares its clock and reset.
- Valid/ready start handshake, one-cycle result strobe, synchronous cancel for pipeline flush.

Parameters:
WIDTH, 32, operand/quotient/remainder width; iteration count equals WIDTH

Ports:
mul_clk  input  1  clock; all state updates on rising edge
resetn  input  1  synchronous, active-low reset
div_valid  input  1  start request
div_signed  input  1  1 = signed (two's complement) operation, 0 = unsigned
x  input  WIDTH  dividend; sampled on accept only
y  input  WIDTH  divisor; sampled on accept only
cancel  input  1  flush; aborts any operation in progress
div_ready  output  1  high in IDLE and DONE; may accept a new operation
out_valid  output  1  one-cycle pulse; quotient/remainder valid
quotient  output  WIDTH  result quotient; held until next accept
remainder  output  WIDTH  result remainder; held until next accept

Behaviour:
- Reset (resetn=0 at an edge): state IDLE; out_valid=0, quotient=0, remainder=0, div_ready=1. Reset wins over every other input, including mid-operation.
- Accept when div_valid & div_ready & ~cancel.
  - Latch sign_q = div_signed & (x[W-1]^y[W-1]) and sign_r = div_signed & x[W-1].
  - Latch magnitudes |x| and |y|; negate only if div_signed and the MSB is set.
  - |0x80000000| = 0x80000000 treated as unsigned.
- States: IDLE -> CALC (32 iterations, counter 0..31) -> FIX -> DONE -> IDLE, or DONE -> CALC on a new accept.
- CALC, one iteration per cycle on a 2W-bit partial remainder:
  - shift left by 1; trial-subtract |y|<<W.
  - If non-negative: keep the difference and shift 1 into the quotient; else restore and shift 0.
- FIX: quotient = sign_q ? -Q : Q; remainder = sign_r ? -R : R. Both registered at the FIX edge.
- Latency: accept in cycle N -> out_valid=1 in cycle N+34 only; div_ready=1 in that cycle.
- Remainder sign follows the dividend; |remainder| < |divisor|.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0 (wrap, no trap).
- Divide by zero: no trap; natural restoring results, regardless of latency:
  - unsigned: Q=0xFFFFFFFF, R=x.
  - signed, x>=0: Q=0xFFFFFFFF, R=x.
  - signed, x<0: Q=0x00000001, R=x.
- cancel:
  - In CALC/FIX: next state IDLE; no out_valid; quotient/remainder keep their previous values.
  - Asserted with div_valid in the same cycle: request not accepted.
  - In DONE: out_valid already high that cycle is unaffected; next state IDLE.
- x/y/div_signed changes after accept have no effect.
- div_valid while busy is ignored; the requester must hold it until div_ready.

Optional Feature:
DIV_FAST_ZERO_EN
- Defined: y==0 at accept skips CALC/FIX. Next edge loads the divide-by-zero values listed above and enters DONE; out_valid in cycle N+1.
- Not defined: divide-by-zero takes the full 34-cycle path.
- Result values are identical either way; only latency differs. Nonzero divisors are unaffected.

Test Plan:
- Unsigned 100/7 accepted cycle N -> out_valid only in N+34; quotient=14, remainder=2; div_ready low N+1..N+33.
- Signed -7/2 (0xFFFFFFF9, 0x00000002) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Same operands unsigned -> quotient=0x7FFFFFFC, remainder=1.
- Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0. Unsigned 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
- Divide by zero:
  - signed x=0xFFFFFFF0, y=0 -> quotient=1, remainder=0xFFFFFFF0.
  - unsigned x=5, y=0 -> quotient=0xFFFFFFFF, remainder=5.
  - Latency N+34 without macro, N+1 with DIV_FAST_ZERO_EN.
- cancel at N+10 -> no out_valid ever; div_ready=1 in N+11; new op 9/3 accepted N+11 -> quotient=3, remainder=0 in N+45.
- Control corner cases:
  - resetn=0 at N+20 -> all outputs 0, div_ready=1 next cycle, no out_valid.
  - Back-to-back accept in the DONE cycle -> second result exactly 34 cycles later.

Source files
------------

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider, WIDTH-bit signed/unsigned.
// Optional DIV_FAST_ZERO_EN: a zero divisor completes one cycle after accept.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             mul_clk,
    input  logic             resetn,
    input  logic             div_valid,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cancel,
    output logic             div_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [2*WIDTH-1:0] rem_q;
    logic [2*WIDTH-1:0] rem_next;
    logic [WIDTH-1:0]   dvs_q;
    logic [CW-1:0]      cnt_q;
    logic               neg_q, neg_r;
    logic               accept, fast_zero;
    logic               x_neg, y_neg;
    logic [WIDTH-1:0]   x_abs, y_abs;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   q_fix, r_fix, zq;

    assign x_neg = div_signed & x[WIDTH-1];
    assign y_neg = div_signed & y[WIDTH-1];
    assign x_abs = x_neg ? -x : x;
    assign y_abs = y_neg ? -y : y;

`ifdef DIV_FAST_ZERO_EN
    assign fast_zero = (y == '0);
`else
    assign fast_zero = 1'b0;
`endif

    // Zero divisor: restoring loop yields all-ones, negated when x < 0.
    assign zq = x_neg ? {{(WIDTH-1){1'b0}}, 1'b1} : '1;

    // Upper W+1 bits hold the shifted partial remainder (may reach 2^W).
    assign trial    = rem_q[2*WIDTH-1:WIDTH-1] - {1'b0, dvs_q};
    assign rem_next = trial[WIDTH]
                    ? {rem_q[2*WIDTH-2:0], 1'b0}
                    : {trial[WIDTH-1:0], rem_q[WIDTH-2:0], 1'b1};

    assign q_fix = neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    assign r_fix = neg_r ? -rem_q[2*WIDTH-1:WIDTH] : rem_q[2*WIDTH-1:WIDTH];

    always_ff @(posedge mul_clk) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        div_ready = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                div_ready = 1'b1;
                out_valid = (state_q == DONE);
                accept    = div_valid & ~cancel;
                state_d   = IDLE;
                if (accept) state_d = fast_zero ? DONE : CALC;
            end
            CALC: begin
                if (cancel)                        state_d = IDLE;
                else if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                state_d = cancel ? IDLE : DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mul_clk) begin
        if (!resetn) begin
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (accept) begin
            rem_q <= {{WIDTH{1'b0}}, x_abs};
            dvs_q <= y_abs;
            cnt_q <= '0;
            neg_q <= x_neg ^ y_neg;
            neg_r <= x_neg;
            if (fast_zero) begin
                quotient  <= zq;
                remainder <= x;
            end
        end else if (state_q == CALC) begin
            rem_q <= rem_next;
            cnt_q <= cnt_q + CW'(1);
        end else if (state_q == FIX && !cancel) begin
            quotient  <= q_fix;
            remainder <= r_fix;
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: table-driven and scoreboard checks for div_iter.
module tb_div_iter;
    logic        mul_clk = 1'b0;
    logic        resetn;
    logic        div_valid;
    logic        div_signed;
    logic [31:0] x, y;
    logic        cancel;
    logic        div_ready, out_valid;
    logic [31:0] quotient, remainder;

`ifdef DIV_FAST_ZERO_EN
    localparam int ZL = 1;
`else
    localparam int ZL = 34;
`endif

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          due;
    } exp_t;

    vec_t        vt[13];
    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_q = 32'd0;
    logic [31:0] last_r = 32'd0;

    div_iter dut (
        .mul_clk   (mul_clk),
        .resetn    (resetn),
        .div_valid (div_valid),
        .div_signed(div_signed),
        .x         (x),
        .y         (y),
        .cancel    (cancel),
        .div_ready (div_ready),
        .out_valid (out_valid),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 mul_clk = ~mul_clk;
    always @(posedge mul_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h cyc=%0d",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge mul_clk) begin
        if (resetn && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_out_valid cyc=%0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("latency_cycle", cyc, e.due);
                last_q = e.q;
                last_r = e.r;
            end
        end
    end

    // Called at a negedge; returns #1 after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic push,
                         input logic [31:0] eq, input logic [31:0] er,
                         input int lat);
        int n;
        x          = a;
        y          = b;
        div_signed = s;
        div_valid  = 1'b1;
        for (int i = 0; i < 100 && !div_ready; i++) @(negedge mul_clk);
        if (!div_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=0 required=1 cyc=%0d", cyc);
            div_valid = 1'b0;
            return;
        end
        n = cyc;
        if (push) sb.push_back('{eq, er, n + lat});
        @(posedge mul_clk);
        #1;
        div_valid  = 1'b0;
        x          = $urandom;
        y          = $urandom;
        div_signed = 1'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge mul_clk);
            #2;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL result_timeout actual=%0d required=0", sb.size());
            sb.delete();
        end
        @(negedge mul_clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic bad;
        vt[0]  = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2};
        vt[1]  = '{32'hFFFFFFF9,  32'h00000002,  1'b1, 32'hFFFFFFFD,  32'hFFFFFFFF};
        vt[2]  = '{32'hFFFFFFF9,  32'h00000002,  1'b0, 32'h7FFFFFFC,  32'h00000001};
        vt[3]  = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000,  32'h00000000};
        vt[4]  = '{32'hFFFFFFFF,  32'h00000001,  1'b0, 32'hFFFFFFFF,  32'h00000000};
        vt[5]  = '{32'hFFFFFFF0,  32'h00000000,  1'b1, 32'h00000001,  32'hFFFFFFF0};
        vt[6]  = '{32'd5,         32'd0,         1'b0, 32'hFFFFFFFF,  32'd5};
        vt[7]  = '{32'd9,         32'd3,         1'b0, 32'd3,         32'd0};
        vt[8]  = '{32'd7,         32'hFFFFFFFE,  1'b1, 32'hFFFFFFFD,  32'd1};
        vt[9]  = '{32'hFFFFFFF9,  32'hFFFFFFFE,  1'b1, 32'd3,         32'hFFFFFFFF};
        vt[10] = '{32'h80000000,  32'h80000001,  1'b0, 32'd0,         32'h80000000};
        vt[11] = '{32'hFFFFFFFF,  32'h80000000,  1'b0, 32'd1,         32'h7FFFFFFF};
        vt[12] = '{32'h80000000,  32'h00000000,  1'b1, 32'd1,         32'h80000000};

        resetn = 1'b0; div_valid = 1'b0; div_signed = 1'b0;
        x = '0; y = '0; cancel = 1'b0;
        repeat (3) @(posedge mul_clk);
        #1 resetn = 1'b1;
        @(negedge mul_clk);
        chk("reset_ready", 32'(div_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_quotient", quotient, 32'd0);
        chk("reset_remainder", remainder, 32'd0);

        // 100/7: ready must stay low N+1..N+33, high at N+34
        issue(32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 32'd2, 34);
        bad = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge mul_clk);
            if (div_ready) bad = 1'b1;
        end
        chk("busy_ready_low", 32'(bad), 32'd0);
        @(negedge mul_clk);
        chk("done_ready", 32'(div_ready), 32'd1);
        wait_done();

        foreach (vt[i]) begin
            issue(vt[i].x, vt[i].y, vt[i].s, 1'b1, vt[i].q, vt[i].r,
                  (vt[i].y == 32'd0) ? ZL : 34);
            wait_done();
        end

        // cancel at N+10, then 9/3 accepted at N+11
        issue(32'd1000, 32'd3, 1'b0, 1'b0, 32'd0, 32'd0, 34);
        repeat (9) @(posedge mul_clk);
        #1 cancel = 1'b1;
        @(posedge mul_clk);
        #1 cancel = 1'b0;
        @(negedge mul_clk);
        chk("cancel_ready", 32'(div_ready), 32'd1);
        chk("cancel_keep_q", quotient, last_q);
        chk("cancel_keep_r", remainder, last_r);
        issue(32'd9, 32'd3, 1'b0, 1'b1, 32'd3, 32'd0, 34);
        wait_done();

        // cancel together with div_valid: not accepted
        x = 32'd20; y = 32'd4; div_signed = 1'b0;
        div_valid = 1'b1; cancel = 1'b1;
        @(posedge mul_clk);
        #1 div_valid = 1'b0; cancel = 1'b0;
        @(negedge mul_clk);
        chk("cancel_blocks_accept", 32'(div_ready), 32'd1);

        // reset mid-operation at N+20
        issue(32'd50, 32'd5, 1'b0, 1'b0, 32'd0, 32'd0, 34);
        repeat (19) @(posedge mul_clk);
        #1 resetn = 1'b0;
        @(posedge mul_clk);
        #1 resetn = 1'b1;
        @(negedge mul_clk);
        chk("midreset_ready", 32'(div_ready), 32'd1);
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_quotient", quotient, 32'd0);
        chk("midreset_remainder", remainder, 32'd0);
        repeat (40) @(negedge mul_clk);

        // back-to-back: second accept in the DONE cycle
        issue(32'd1234, 32'd10, 1'b0, 1'b1, 32'd123, 32'd4, 34);
        for (int i = 0; i < 60 && !out_valid; i++) @(negedge mul_clk);
        chk("b2b_first_done", 32'(out_valid), 32'd1);
        issue(32'hFFFFFF9C, 32'd7, 1'b1, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 34);
        wait_done();

        repeat (5) @(negedge mul_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
